// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, MSB-first data, oversampled line with a 2-flop synchronizer.
// A received byte is held with a valid/ack handshake; framing and overrun errors pulse for one cycle.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       serial_in_i,
    input  logic       data_ack_i,
    output logic [7:0] data_out_o,
    output logic       data_valid_o,
    output logic       rx_busy_o,
    output logic       framing_error_o,
    output logic       overrun_o
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

    state_e        state_q, state_d;
    logic          sync1_q, rxs_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          fe_q, fe_d;
    logic          ovr_q, ovr_d;
    logic          good;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= serial_in_i;
            rxs_q   <= sync1_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ovr_d   = 1'b0;
        good    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == TICK_HALF) begin
                    if (!rxs_q) begin
                        state_d = DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == TICK_LAST) begin
                    shift_d = {shift_q[6:0], rxs_q};
                    tick_d  = '0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (rxs_q) begin
                        good    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not be re-read as a stream of frames.
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // An ack in the landing cycle frees the holding register for the new byte.
        if (good) begin
            if (!valid_q || data_ack_i) begin
                dout_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (data_ack_i) begin
            valid_d = 1'b0;
        end
    end

    assign data_out_o      = dout_q;
    assign data_valid_o    = valid_q;
    assign rx_busy_o       = (state_q != IDLE);
    assign framing_error_o = fe_q;
    assign overrun_o       = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: three instances (OVERSAMPLE 16, 8, 4) driven by a bit-level line model;
// expected byte/overrun/framing events and their arrival cycle come from frame arithmetic.
module tb_uart_rx;
    localparam int N = 3;

    typedef enum {EV_GOOD, EV_OVR, EV_FE} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
        logic       valid;
        int         cyc;
    } exp_t;

    logic           clk = 1'b0;
    int             cyc = 0;
    logic [N-1:0]   rst, ser, ack, busy, vld, fe, ovr;
    logic [7:0]     dout [N];

    exp_t           exp_q [N][$];
    logic           model_valid [N];
    logic [7:0]     model_data  [N];
    int             n_chk = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int os_of(input int i);
        return (i == 0) ? 16 : (i == 1) ? 8 : 4;
    endfunction

    // Compare a DUT event with the oldest expectation; cycle is the rising edge that first sees it.
    task automatic check_ev(input int i, input ev_e k);
        exp_t e;
        n_chk++;
        if (exp_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event dut%0d kind=%s data=%02h at_cyc=%0d", i, k.name(), dout[i], cyc + 1);
            return;
        end
        e = exp_q[i].pop_front();
        if (e.kind != k || e.data != dout[i] || e.valid != vld[i] || e.cyc != cyc + 1) begin
            n_fail++;
            $display("FAIL event dut%0d got kind=%s data=%02h valid=%0b cyc=%0d want kind=%s data=%02h valid=%0b cyc=%0d",
                     i, k.name(), dout[i], vld[i], cyc + 1, e.kind.name(), e.data, e.valid, e.cyc);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic       pv;
        logic [7:0] pd;

        uart_rx #(.OVERSAMPLE((g == 0) ? 16 : (g == 1) ? 8 : 4)) u_dut (
            .clk_i          (clk),
            .reset_i        (rst[g]),
            .serial_in_i    (ser[g]),
            .data_ack_i     (ack[g]),
            .data_out_o     (dout[g]),
            .data_valid_o   (vld[g]),
            .rx_busy_o      (busy[g]),
            .framing_error_o(fe[g]),
            .overrun_o      (ovr[g])
        );

        always @(negedge clk) begin
            if (rst[g]) begin
                pv <= 1'b0;
                pd <= 8'h00;
            end else begin
                if (fe[g])  check_ev(g, EV_FE);
                if (ovr[g]) check_ev(g, EV_OVR);
                if (vld[g] && (!pv || dout[g] != pd)) check_ev(g, EV_GOOD);
                pv <= vld[g];
                pd <= dout[g];
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse(input int i);
        ack[i] = 1'b1;
        idle(1);
        ack[i] = 1'b0;
        model_valid[i] = 1'b0;
    endtask

    // Drives one 10-bit frame; ack_c >= 0 raises DataAck for the cycle after line cycle ack_c.
    task automatic send_frame(input int i, input logic [7:0] b, input logic stop, input int ack_c);
        int         os;
        int         stopc;
        logic [9:0] bits;
        exp_t       e;
        os    = os_of(i);
        stopc = 2 + os / 2 + 9 * os;
        bits  = {1'b0, b, stop};
        e.cyc = cyc + 3 + os / 2 + 9 * os + 1;
        if (!stop) begin
            e.kind = EV_FE;
        end else if (model_valid[i] && !(ack_c >= 0 && ack_c <= stopc)) begin
            e.kind = EV_OVR;
        end else begin
            e.kind = EV_GOOD;
            model_valid[i] = 1'b1;
            model_data[i]  = b;
        end
        e.data  = model_data[i];
        e.valid = model_valid[i];
        exp_q[i].push_back(e);
        for (int c = 0; c < 10 * os; c++) begin
            ser[i] = bits[9 - c / os];
            ack[i] = (c == ack_c);
            idle(1);
        end
        ack[i] = 1'b0;
    endtask

    initial begin
        int   stopc;
        int   ac;
        logic all_empty;
        rst = '1;
        ser = '1;
        ack = '0;
        for (int i = 0; i < N; i++) begin
            model_valid[i] = 1'b0;
            model_data[i]  = 8'h00;
        end
        @(posedge clk);
        #1;
        idle(1);
        for (int i = 0; i < N; i++)
            check($sformatf("reset_state_dut%0d", i),
                  {dout[i], vld[i], busy[i], fe[i], ovr[i]}, 32'h0);
        rst = '0;

        // single byte and ack
        send_frame(0, 8'h92, 1'b1, -1);
        idle(20);
        check("single_dout", dout[0], 8'h92);
        check("single_valid", vld[0], 1);
        ack_pulse(0);
        check("ack_clears_valid", vld[0], 0);

        // false start
        ser[0] = 1'b0;
        idle(5);
        ser[0] = 1'b1;
        check("glitch_busy", busy[0], 1);
        idle(20);
        check("glitch_idle", {busy[0], vld[0], fe[0]}, 0);

        // framing error then break
        send_frame(0, 8'hA5, 1'b0, -1);
        idle(40);
        check("wait_high_busy", busy[0], 1);
        check("fe_no_valid", vld[0], 0);
        ser[0] = 1'b1;
        idle(5);
        check("wait_high_release", busy[0], 0);
        send_frame(0, 8'h3C, 1'b1, -1);
        idle(20);
        check("after_fe_dout", dout[0], 8'h3C);
        ack_pulse(0);

        // overrun, then same-cycle ack
        send_frame(0, 8'h11, 1'b1, -1);
        send_frame(0, 8'h22, 1'b1, -1);
        idle(20);
        check("overrun_keep_dout", dout[0], 8'h11);
        ack_pulse(0);
        stopc = 2 + 8 + 9 * 16;
        send_frame(0, 8'h11, 1'b1, -1);
        send_frame(0, 8'h22, 1'b1, stopc);
        idle(20);
        check("same_cycle_ack_dout", dout[0], 8'h22);
        check("same_cycle_ack_valid", vld[0], 1);

        // reset during data bit 4 of 0xFF, with 0x22 still pending
        ser[0] = 1'b0;
        idle(16);
        ser[0] = 1'b1;
        idle(16 * 4 + 8);
        check("midframe_busy", busy[0], 1);
        rst[0] = 1'b1;
        idle(2);
        rst[0] = 1'b0;
        model_valid[0] = 1'b0;
        model_data[0]  = 8'h00;
        check("midframe_reset_outputs", {dout[0], vld[0], busy[0], fe[0], ovr[0]}, 0);
        idle(20);
        check("midframe_no_event", {vld[0], busy[0]}, 0);
        send_frame(0, 8'h00, 1'b1, -1);
        idle(20);
        check("after_reset_valid", vld[0], 1);

        // small oversample ratios, back-to-back
        for (int i = 1; i < N; i++) begin
            send_frame(i, 8'h5A, 1'b1, -1);
            send_frame(i, 8'hC3, 1'b1, os_of(i));
            idle(4 * os_of(i));
            check($sformatf("sweep_dout_dut%0d", i), dout[i], 8'hC3);
        end

        // random frames with random early acks and gaps
        for (int i = 0; i < N; i++) begin
            stopc = 2 + os_of(i) / 2 + 9 * os_of(i);
            for (int f = 0; f < 8; f++) begin
                ac = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, stopc - 1)) : -1;
                send_frame(i, 8'($urandom), 1'b1, ac);
                idle($urandom_range(0, os_of(i)));
            end
        end

        all_empty = 1'b0;
        for (int t = 0; t < 2000 && !all_empty; t++) begin
            idle(1);
            all_empty = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
        end
        for (int i = 0; i < N; i++)
            check($sformatf("pending_events_dut%0d", i), exp_q[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the counterpart of the team's UART transmitter. It recovers 10-bit frames from an asynchronous serial line: start bit 0, 8 data bits, stop bit 1, no parity. Data bits arrive most-significant-first, matching the transmitter's shift order. Each received byte is presented with a valid/acknowledge handshake, and framing and overrun conditions are flagged.

## Interface
- OVERSAMPLE, 16: BitClk cycles per bit period; must be even and ≥4.
- BitClk  input  1  sample clock, running at OVERSAMPLE × baud rate.
- Reset  input  1  synchronous, active-high reset. Sampled on the BitClk rising edge.
- SerialIn  input  1  asynchronous serial line; idles high.
- DataAck  input  1  consumer acknowledge. Clears DataValid.
- DataOut  output  8  last good byte. Bit 7 is the first data bit received.
- DataValid  output  1  DataOut holds an unacknowledged byte.
- RxBusy  output  1  high while a frame is being received (any state other than IDLE).
- FramingError  output  1  one-cycle pulse when the stop bit samples 0.
- Overrun  output  1  one-cycle pulse when a good byte is dropped because DataValid was still pending.

## Operation
- **Synchronizer.** SerialIn passes through a 2-flop synchronizer; the FSM sees only the synced signal (rxs). Both flops reset to 1.
- **Counters.** The tick counter is ceil(log2(OVERSAMPLE)) bits wide. The bit counter is 3 bits, counting 0–7.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rxs = 0 → START, tick counter cleared.
  - START: at tick OVERSAMPLE/2−1, sample rxs.
    - 0 → DATA, tick and bit counters cleared.
    - 1 → false start, return to IDLE with no flag.
  - DATA: at tick OVERSAMPLE−1, shift rxs into the shift register from the LSB side (first bit ends in bit 7) and clear the tick counter.
    - After bit counter = 7 → STOP.
  - STOP: at tick OVERSAMPLE−1, sample rxs.
    - 1 → good byte, go to IDLE.
    - 0 → pulse FramingError, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs = 1, then → IDLE. This prevents a break condition being read as repeated frames.
- **Good-byte delivery**, evaluated in the same cycle as the stop sample:
  - DataValid = 0, or DataAck = 1 that cycle → load DataOut, DataValid = 1.
  - DataValid = 1 and DataAck = 0 → keep DataOut and DataValid, pulse Overrun, drop the new byte.
- **Handshake.** DataAck = 1 with DataValid = 1 and no byte landing that cycle → DataValid = 0 the next cycle. DataAck while DataValid = 0 is ignored.
- **Back-to-back frames.** Returning to IDLE at mid-stop-bit lets the next start edge be detected without gaps.

## Timing
- **Reset.** Reset = 1 forces state IDLE, both counters 0, and synchronizer flops 1. Outputs reset to: DataOut = 0x00, DataValid = 0, RxBusy = 0, FramingError = 0, Overrun = 0.
  - Reset mid-frame aborts the frame; no flag or byte is produced.
- **Reference point.** Let t0 be the first rising edge at which IDLE sees rxs = 0. t0 is 2 cycles after the SerialIn falling edge is first sampled.
- **Sample points:**
  - Start bit: t0 + OVERSAMPLE/2.
  - Data bit k (k = 0..7): t0 + OVERSAMPLE/2 + (k+1)·OVERSAMPLE.
  - Stop bit: t0 + OVERSAMPLE/2 + 9·OVERSAMPLE, i.e. t0 + 152 at default.
- **Stop-sample outputs.** DataValid, DataOut, FramingError and Overrun update on the edge after the stop sample (t0 + 153 at default).
  - FramingError and Overrun are high for exactly one cycle.
- **RxBusy.** High from t0 + 1 until the cycle the FSM re-enters IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single byte.** Reset 2 cycles, then send 0x92 at OVERSAMPLE = 16 (line 0,1,0,0,1,0,0,1,0,1, each 16 cycles) → DataOut = 0x92 and DataValid = 1 at t0 + 153. DataAck for 1 cycle → DataValid = 0 next cycle.
- **False start.** 5-cycle low glitch on an idle line → FSM returns to IDLE; DataValid, FramingError and RxBusy are 0 after the return.
- **Framing error.** Frame 0xA5 with stop bit 0, line held low 40 more cycles → one FramingError pulse, DataValid stays 0, RxBusy stays high until the line returns high. A following 0x3C frame is received correctly.
- **Overrun and same-cycle ack.**
  - Send 0x11 then 0x22 back-to-back with no ack → Overrun pulses once, DataOut stays 0x11.
  - Repeat with DataAck asserted in the 0x22 stop-sample cycle → DataOut = 0x22, DataValid stays 1, no Overrun.
- **Reset mid-frame.** Assert Reset during data bit 4 of 0xFF → all outputs return to their reset values. A subsequent 0x00 frame yields DataOut = 0x00 with DataValid = 1.
- **Parameter sweep.** OVERSAMPLE = 4 and 8: 0x5A and 0xC3 received back-to-back correctly, with DataValid at t0 + OVERSAMPLE/2 + 9·OVERSAMPLE + 1.
